pipe_src_arbiter: RTL and testbench

Clocked round-robin arbiter that shares one asynchronous two-phase bundled-data pipeline input among NUM_SRC synchronous producers. It selects a requester, captures its word, and holds it on data_out as stable bundled data. It then toggles req_out, waits for the pipeline's acknowledge toggle, and rearbitrates. It sits between the clocked front-end and the req/ack pipeline stage chain. It owns all sequencing of that pipeline's input handshake.

---
 rtl/pipe_src_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_pipe_src_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_src_arbiter.sv
// Round-robin arbiter feeding one two-phase bundled-data pipeline input from NUM_SRC clocked producers.
// Optional ack watchdog: define PIPE_SRC_ARBITER_TIMEOUT_EN to build the sticky timeout_err flag.
module pipe_src_arbiter #(
    parameter int DATA_WIDTH  = 3,
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic                          req_out,
    output logic [DATA_WIDTH-1:0]         data_out,
    input  logic                          ack_in,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          timeout_err,
    output logic [1:0]                    dbg_state
);

    // Handshakes: a source holds src_valid until its one-cycle src_ready pulse and the word
    // transfers on the edge ending that pulse; toward the pipeline each req_out toggle offers
    // one word on data_out, which stays frozen until ack (synchronized) equals req_out again.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SETUP = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q;
    logic                    ack_s;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         grant_id_q, grant_id_d;
    logic [ID_W-1:0]         pick_id;
    logic [ID_W-1:0]         ptr_inc;
    logic                    pick_vld;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    req_q, req_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // Scan downward so the smallest offset from ptr is the last (winning) assignment.
    always_comb begin
        int            idx;
        logic [ID_W-1:0] idx_v;
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = 0;
        idx_v    = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            idx_v = ID_W'(idx);
            if (src_valid[idx_v]) begin
                pick_vld = 1'b1;
                pick_id  = idx_v;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                sel_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ptr_inc = (grant_id_q == ID_W'(NUM_SRC - 1)) ? '0 : grant_id_q + ID_W'(1);

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        data_d     = data_q;
        req_d      = req_q;
        src_ready  = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_id_d = pick_id;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                src_ready[grant_id_q] = 1'b1;
                data_d  = sel_data;
                ptr_d   = ptr_inc;
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                req_d   = ~req_q;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ack_s == req_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            data_q     <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            data_q     <= data_d;
            req_q      <= req_d;
        end
    end

`ifdef PIPE_SRC_ARBITER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             to_err_q, to_err_d;

    // The FSM never leaves WAIT on timeout; the flag only reports a stalled pipeline.
    always_comb begin
        to_cnt_d = to_cnt_q;
        to_err_d = to_err_q;
        if (state_q == ST_SETUP) begin
            to_cnt_d = '0;
        end else if (state_q == ST_WAIT && to_cnt_q != CNT_W'(TIMEOUT)) begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
        end
        if (state_q == ST_WAIT && state_d == ST_WAIT && to_cnt_d == CNT_W'(TIMEOUT)) begin
            to_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign timeout_err = to_err_q;
`else
    // No watchdog: constant 0 for every legal (non-negative) TIMEOUT.
    assign timeout_err = (TIMEOUT < 0);
`endif

    assign req_out   = req_q;
    assign data_out  = data_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pipe_src_arbiter.sv
// Directed bench for pipe_src_arbiter with a small two-phase pipeline ack model.
module tb_pipe_src_arbiter;
    localparam int DW  = 3;
    localparam int NS  = 4;
    localparam int SS  = 2;
    localparam int TO  = 8;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NS-1:0]    src_valid = '0;
    logic [NS*DW-1:0] src_data = '0;
    logic [NS-1:0]    src_ready;
    logic             req_out;
    logic [DW-1:0]    data_out;
    logic             ack_in = 1'b0;
    logic [IDW-1:0]   grant_id;
    logic             busy;
    logic             timeout_err;
    logic [1:0]       dbg_state;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  ack_en  = 1'b0;
    int  ack_dly = 1;
    int  ack_cnt = 0;
    int  exp_gid[5]  = '{0, 1, 2, 3, 0};
    int  exp_data[5] = '{4, 5, 6, 7, 4};
    logic exp_err;

    pipe_src_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_SRC    (NS),
        .SYNC_STAGES(SS),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .req_out    (req_out),
        .data_out   (data_out),
        .ack_in     (ack_in),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        ack_in = 1'b0;
        src_valid = '0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int i;
        i = 0;
        while (src_ready == '0 && i < 50) begin
            tick();
            i++;
        end
        check(tag, 32'(src_ready != '0), 1);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy && i < 60) begin
            tick();
            i++;
        end
        check(tag, 32'(busy), 0);
    endtask

    // pipeline model: echoes req_out onto ack_in ack_dly sample points after a mismatch
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ack_cnt = 0;
            end else if (ack_en && req_out != ack_in) begin
                ack_cnt++;
                if (ack_cnt >= ack_dly) begin
                    ack_in = req_out;
                    ack_cnt = 0;
                end
            end
        end
    end

    initial begin
        int w;
        int cnt;
        logic exp_req;

`ifdef PIPE_SRC_ARBITER_TIMEOUT_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        // reset state
        do_reset();
        check("rst_req", 32'(req_out), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_ready", 32'(src_ready), 0);
        check("rst_gid", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_terr", 32'(timeout_err), 0);
        check("rst_state", 32'(dbg_state), 0);

        // single word from source 0, cycle-exact
        ack_en = 1'b1;
        ack_dly = 1;
        src_data[2:0] = 3'd1;
        src_valid = 4'b0001;
        tick();
        check("t1_ready", 32'(src_ready), 32'h1);
        check("t1_gid", 32'(grant_id), 0);
        check("t1_state", 32'(dbg_state), 1);
        src_valid = '0;
        tick();
        check("t1_data", 32'(data_out), 1);
        check("t1_req_pre", 32'(req_out), 0);
        check("t1_ready_off", 32'(src_ready), 0);
        tick();
        check("t1_req", 32'(req_out), 1);
        check("t1_wait", 32'(dbg_state), 3);
        tick();
        check("t1_busy_a", 32'(busy), 1);
        tick();
        check("t1_busy_b", 32'(busy), 1);
        tick();
        check("t1_busy_c", 32'(busy), 0);
        check("t1_req_hold", 32'(req_out), 1);

        // all sources valid: strict rotation
        do_reset();
        ack_en = 1'b1;
        ack_dly = 1;
        src_data = {3'd7, 3'd6, 3'd5, 3'd4};
        src_valid = 4'b1111;
        for (w = 0; w < 5; w++) begin
            wait_ready("t2_grant_seen");
            check("t2_gid", 32'(grant_id), exp_gid[w]);
            check("t2_ready", 32'(src_ready), 32'(1) << exp_gid[w]);
            if (w == 4) src_valid = '0;
            tick();
            check("t2_data", 32'(data_out), exp_data[w]);
            wait_idle("t2_idle");
        end

        // single source back-to-back with slow ack
        do_reset();
        ack_en = 1'b1;
        ack_dly = 10;
        src_data = '0;
        src_data[8:6] = 3'd1;
        src_valid = 4'b0100;
        exp_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wait_ready("t3_grant_seen");
            check("t3_ready", 32'(src_ready), 32'h4);
            if (k == 5) src_valid = '0;
            tick();
            check("t3_data", 32'(data_out), k);
            src_data[8:6] = 3'(k + 1);
            tick();
            exp_req = ~exp_req;
            check("t3_req", 32'(req_out), 32'(exp_req));
            cnt = 0;
            while (busy && cnt < 60) begin
                check("t3_data_hold", 32'(data_out), k);
                check("t3_req_hold", 32'(req_out), 32'(exp_req));
                tick();
                cnt++;
            end
            check("t3_wait_len", cnt, 12);
            check("t3_ack_match", 32'(ack_in), 32'(exp_req));
        end

        // asynchronous reset while waiting with req_out=1
        do_reset();
        ack_en = 1'b0;
        src_data = '0;
        src_data[5:3] = 3'd5;
        src_valid = 4'b0010;
        wait_ready("t4_grant_seen");
        check("t4_gid_pre", 32'(grant_id), 1);
        src_valid = '0;
        tick();
        tick();
        check("t4_req_pre", 32'(req_out), 1);
        tick();
        tick();
        check("t4_state_pre", 32'(dbg_state), 3);
        #2;
        rst_n = 1'b0;
        ack_in = 1'b0;
        #1;
        check("t4_rst_req", 32'(req_out), 0);
        check("t4_rst_data", 32'(data_out), 0);
        check("t4_rst_ready", 32'(src_ready), 0);
        check("t4_rst_gid", 32'(grant_id), 0);
        check("t4_rst_busy", 32'(busy), 0);
        check("t4_rst_state", 32'(dbg_state), 0);
        src_data = '0;
        src_data[2:0] = 3'd2;
        src_data[11:9] = 3'd3;
        src_valid = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        ack_dly = 1;
        tick();
        wait_ready("t4_grant0_seen");
        check("t4_ready0", 32'(src_ready), 32'h1);
        check("t4_gid0", 32'(grant_id), 0);
        src_valid[0] = 1'b0;
        tick();
        check("t4_data0", 32'(data_out), 2);
        wait_idle("t4_idle0");
        wait_ready("t4_grant3_seen");
        check("t4_gid3", 32'(grant_id), 3);
        src_valid = '0;
        tick();
        check("t4_data3", 32'(data_out), 3);
        wait_idle("t4_idle3");

        // ack never returns
        do_reset();
        ack_en = 1'b0;
        src_data = '0;
        src_data[2:0] = 3'd6;
        src_valid = 4'b0001;
        wait_ready("t5_grant_seen");
        src_valid = '0;
        tick();
        tick();
        check("t5_wait", 32'(dbg_state), 3);
        repeat (7) tick();
        check("t5_pre", 32'(timeout_err), 0);
        tick();
        check("t5_rise", 32'(timeout_err), 32'(exp_err));
        repeat (5) tick();
        check("t5_hold", 32'(timeout_err), 32'(exp_err));
        check("t5_state", 32'(dbg_state), 3);
        check("t5_data", 32'(data_out), 6);
        do_reset();
        check("t5_clear", 32'(timeout_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
